apb2axi: RTL and testbench
==========================

// Module: apb2axi
// PURPOSE
//  APB3 slave to AXI4 master bridge: lets an APB initiator (debug/config master) reach the AXI fabric.
//  Each APB access becomes exactly one single-beat 32-bit AXI transaction on a 64-bit data bus.
//  PREADY is held low until the AXI response returns. PSLVERR reflects the AXI response.
// PARAMETERS
//  AXI4_ADDRESS_WIDTH 32  AXI address width (>= APB_ADDR_WIDTH)
//  AXI4_DATA_WIDTH    64  AXI data width; fixed at 64 in this block
//  AXI4_ID_WIDTH      16  AXI ID width
//  AXI4_USER_WIDTH    10  AXI user width; AWUSER/ARUSER driven 0
//  APB_ADDR_WIDTH     32  PADDR width
//  AXI_ID             0   constant ID driven on AWID_o/ARID_o
// PORTS
//  ACLK      in  1   clock
//  ARESETn   in  1   async active-low reset
//  PSEL/PENABLE/PWRITE  in  1  APB control
//  PADDR     in  APB_ADDR_WIDTH  APB byte address
//  PWDATA    in  32  APB write data
//  PRDATA    out 32  APB read data
//  PREADY    out 1   APB transfer complete
//  PSLVERR   out 1   APB error
//  AWID_o,AWADDR_o,AWLEN_o(8),AWSIZE_o(3),AWBURST_o(2),AWLOCK_o,AWCACHE_o(4),AWPROT_o(3),AWREGION_o(4),AWQOS_o(4),AWUSER_o  out  AW channel
//  AWVALID_o out / AWREADY_i in  AW handshake
//  WDATA_o out 64, WSTRB_o out 8, WLAST_o out 1, WUSER_o out  W payload
//  WVALID_o out / WREADY_i in  W handshake
//  BID_i,BRESP_i(2),BUSER_i,BVALID_i  in; BREADY_o out  B channel
//  ARID_o..ARUSER_o  out  AR channel, same field set and constants as AW
//  ARVALID_o out / ARREADY_i in  AR handshake
//  RID_i,RDATA_i(64),RRESP_i(2),RLAST_i,RUSER_i,RVALID_i  in; RREADY_o out  R channel
// BEHAVIOUR
//  Constants: AxLEN=0, AxSIZE=3'b010, AxBURST=2'b01, AxLOCK/CACHE/PROT/REGION/QOS/USER=0, WLAST=1, Ax ID=AXI_ID.
//  AxADDR = {zero-extended PADDR[APB_ADDR_WIDTH-1:2], 2'b00}, captured into a register.
//  Write data: WDATA={PWDATA,PWDATA}; WSTRB=8'hF0 if PADDR[2] else 8'h0F.
//  Read: PRDATA = PADDR[2] ? RDATA_i[63:32] : RDATA_i[31:0], registered when the R beat is accepted.
//  Reset: state IDLE; all VALID/READY outputs 0, PREADY=0, PSLVERR=0, PRDATA=0, address/data registers 0.
//  All AXI and APB outputs are registered. No combinational path from any input to any output.
//  FSM:
//   IDLE: start on PSEL & ~PENABLE (setup phase) only.
//    Capture PADDR/PWDATA/PWRITE. Next is WR_REQ (set AWVALID_o & WVALID_o) or RD_REQ (set ARVALID_o).
//   WR_REQ: AW and W are tracked independently. Each VALID drops the cycle after its own handshake.
//    When both are done (including the same cycle), next is WR_RESP with BREADY_o=1.
//   WR_RESP: on BVALID_i, capture PSLVERR=BRESP_i[1]; drop BREADY_o; next DONE.
//   RD_REQ: on ARREADY_i, drop ARVALID_o, set RREADY_o=1; next RD_RESP.
//   RD_RESP: on RVALID_i, capture PRDATA and PSLVERR=RRESP_i[1]; drop RREADY_o; next DONE.
//    RLAST_i and RID_i/BID_i are ignored.
//   DONE: PREADY=1 for exactly one cycle, then IDLE. PREADY and PSLVERR are cleared on exit.
//    PRDATA holds its last value.
//  Latency with a zero-wait AXI slave: setup at T0; AxVALID high T1; resp accepted T2; PREADY high T3.
//  This gives 2 APB wait states minimum.
//  Only one outstanding AXI transaction at a time. A new setup phase is ignored unless in IDLE.
//  If PSEL drops mid-transfer (APB violation), the AXI transaction still completes. DONE is then entered and exited normally.
//  VALID stays asserted until handshake, regardless of APB signals (AXI rule).
//  Async reset mid-transaction: outputs return to reset values immediately and the transaction is abandoned.
//   The fabric is reset by the same ARESETn.
//  PSLVERR=1 for SLVERR (2'b10) and DECERR (2'b11). OKAY and EXOKAY give 0.
// TESTING
//  1 Write PADDR=0x1000_0004, PWDATA=0xDEADBEEF, AW/W/B ready at once
//    -> AWADDR=0x1000_0004, WDATA=0xDEADBEEF_DEADBEEF, WSTRB=0xF0, PREADY on cycle 3, PSLVERR=0.
//  2 Read PADDR=0x2000_0000, RDATA_i=0x11112222_33334444 -> ARADDR=0x2000_0000, PRDATA=0x33334444.
//    Repeat with PADDR=0x2000_0004 -> PRDATA=0x11112222.
//  3 Write with AWREADY delayed 3 cycles and WREADY immediate -> WVALID drops after 1 cycle.
//    AWVALID holds 4 cycles; BREADY only after both handshakes.
//  4 Read with RRESP_i=2'b11 (DECERR) -> PSLVERR=1 with PREADY; next transfer returns PSLVERR=0.
//  5 BVALID held off 10 cycles -> PREADY stays 0 for 10 cycles, then is high exactly 1 cycle.
//  6 Assert ARESETn=0 while ARVALID_o=1 -> ARVALID_o=0 immediately.
//    After release, the next read completes normally.

Source files
------------

// File: rtl/apb2axi.sv
// APB3 slave to AXI4 master bridge: every APB access becomes one single-beat
// 32-bit AXI transaction on a 64-bit bus; PREADY waits for the AXI response.
module apb2axi #(
   parameter int unsigned AXI4_ADDRESS_WIDTH = 32,
   parameter int unsigned AXI4_DATA_WIDTH    = 64,
   parameter int unsigned AXI4_ID_WIDTH      = 16,
   parameter int unsigned AXI4_USER_WIDTH    = 10,
   parameter int unsigned APB_ADDR_WIDTH     = 32,
   parameter int unsigned AXI_ID             = 0
) (
   input  logic                            ACLK,
   input  logic                            ARESETn,
   // APB slave
   input  logic                            PSEL,
   input  logic                            PENABLE,
   input  logic                            PWRITE,
   input  logic [APB_ADDR_WIDTH-1:0]       PADDR,
   input  logic [31:0]                     PWDATA,
   output logic [31:0]                     PRDATA,
   output logic                            PREADY,
   output logic                            PSLVERR,
   // AW channel
   output logic [AXI4_ID_WIDTH-1:0]        AWID_o,
   output logic [AXI4_ADDRESS_WIDTH-1:0]   AWADDR_o,
   output logic [7:0]                      AWLEN_o,
   output logic [2:0]                      AWSIZE_o,
   output logic [1:0]                      AWBURST_o,
   output logic                            AWLOCK_o,
   output logic [3:0]                      AWCACHE_o,
   output logic [2:0]                      AWPROT_o,
   output logic [3:0]                      AWREGION_o,
   output logic [3:0]                      AWQOS_o,
   output logic [AXI4_USER_WIDTH-1:0]      AWUSER_o,
   output logic                            AWVALID_o,
   input  logic                            AWREADY_i,
   // W channel
   output logic [AXI4_DATA_WIDTH-1:0]      WDATA_o,
   output logic [AXI4_DATA_WIDTH/8-1:0]    WSTRB_o,
   output logic                            WLAST_o,
   output logic [AXI4_USER_WIDTH-1:0]      WUSER_o,
   output logic                            WVALID_o,
   input  logic                            WREADY_i,
   // B channel
   input  logic [AXI4_ID_WIDTH-1:0]        BID_i,
   input  logic [1:0]                      BRESP_i,
   input  logic [AXI4_USER_WIDTH-1:0]      BUSER_i,
   input  logic                            BVALID_i,
   output logic                            BREADY_o,
   // AR channel
   output logic [AXI4_ID_WIDTH-1:0]        ARID_o,
   output logic [AXI4_ADDRESS_WIDTH-1:0]   ARADDR_o,
   output logic [7:0]                      ARLEN_o,
   output logic [2:0]                      ARSIZE_o,
   output logic [1:0]                      ARBURST_o,
   output logic                            ARLOCK_o,
   output logic [3:0]                      ARCACHE_o,
   output logic [2:0]                      ARPROT_o,
   output logic [3:0]                      ARREGION_o,
   output logic [3:0]                      ARQOS_o,
   output logic [AXI4_USER_WIDTH-1:0]      ARUSER_o,
   output logic                            ARVALID_o,
   input  logic                            ARREADY_i,
   // R channel
   input  logic [AXI4_ID_WIDTH-1:0]        RID_i,
   input  logic [AXI4_DATA_WIDTH-1:0]      RDATA_i,
   input  logic [1:0]                      RRESP_i,
   input  logic                            RLAST_i,
   input  logic [AXI4_USER_WIDTH-1:0]      RUSER_i,
   input  logic                            RVALID_i,
   output logic                            RREADY_o
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_RESP = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t                          state;
   logic [AXI4_ADDRESS_WIDTH-1:0]   ax_addr;
   logic                            hi_word;
   logic                            aw_done;
   logic                            w_done;
   logic                            aw_now;
   logic                            w_now;

   // Single-beat, 32-bit, incrementing, unprivileged transfers only
   assign AWID_o     = AXI4_ID_WIDTH'(AXI_ID);
   assign AWADDR_o   = ax_addr;
   assign AWLEN_o    = 8'd0;
   assign AWSIZE_o   = 3'b010;
   assign AWBURST_o  = 2'b01;
   assign AWLOCK_o   = 1'b0;
   assign AWCACHE_o  = 4'd0;
   assign AWPROT_o   = 3'd0;
   assign AWREGION_o = 4'd0;
   assign AWQOS_o    = 4'd0;
   assign AWUSER_o   = '0;
   assign WLAST_o    = 1'b1;
   assign WUSER_o    = '0;

   assign ARID_o     = AXI4_ID_WIDTH'(AXI_ID);
   assign ARADDR_o   = ax_addr;
   assign ARLEN_o    = 8'd0;
   assign ARSIZE_o   = 3'b010;
   assign ARBURST_o  = 2'b01;
   assign ARLOCK_o   = 1'b0;
   assign ARCACHE_o  = 4'd0;
   assign ARPROT_o   = 3'd0;
   assign ARREGION_o = 4'd0;
   assign ARQOS_o    = 4'd0;
   assign ARUSER_o   = '0;

   // AW and W complete independently; either may finish first or both together
   assign aw_now = aw_done | (AWVALID_o & AWREADY_i);
   assign w_now  = w_done  | (WVALID_o  & WREADY_i);

   logic unused_inputs;
   assign unused_inputs = ^{BID_i, BUSER_i, BRESP_i[0], RID_i, RLAST_i,
                            RUSER_i, RRESP_i[0], PADDR[1:0]};

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state     <= IDLE;
         ax_addr   <= '0;
         hi_word   <= 1'b0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         WDATA_o   <= '0;
         WSTRB_o   <= '0;
         AWVALID_o <= 1'b0;
         WVALID_o  <= 1'b0;
         BREADY_o  <= 1'b0;
         ARVALID_o <= 1'b0;
         RREADY_o  <= 1'b0;
         PRDATA    <= '0;
         PREADY    <= 1'b0;
         PSLVERR   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // Only a setup phase starts a transfer
               if (PSEL && !PENABLE) begin
                  ax_addr <= AXI4_ADDRESS_WIDTH'({PADDR[APB_ADDR_WIDTH-1:2], 2'b00});
                  hi_word <= PADDR[2];
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
                  if (PWRITE) begin
                     WDATA_o   <= {PWDATA, PWDATA};
                     WSTRB_o   <= PADDR[2] ? 8'hF0 : 8'h0F;
                     AWVALID_o <= 1'b1;
                     WVALID_o  <= 1'b1;
                     state     <= WR_REQ;
                  end else begin
                     ARVALID_o <= 1'b1;
                     state     <= RD_REQ;
                  end
               end
            end
            WR_REQ: begin
               if (AWVALID_o && AWREADY_i) AWVALID_o <= 1'b0;
               if (WVALID_o && WREADY_i)   WVALID_o  <= 1'b0;
               aw_done <= aw_now;
               w_done  <= w_now;
               if (aw_now && w_now) begin
                  BREADY_o <= 1'b1;
                  state    <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (BVALID_i) begin
                  PSLVERR  <= BRESP_i[1];
                  BREADY_o <= 1'b0;
                  PREADY   <= 1'b1;
                  state    <= DONE;
               end
            end
            RD_REQ: begin
               if (ARREADY_i) begin
                  ARVALID_o <= 1'b0;
                  RREADY_o  <= 1'b1;
                  state     <= RD_RESP;
               end
            end
            RD_RESP: begin
               if (RVALID_i) begin
                  PRDATA   <= hi_word ? RDATA_i[63:32] : RDATA_i[31:0];
                  PSLVERR  <= RRESP_i[1];
                  RREADY_o <= 1'b0;
                  PREADY   <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               // One-cycle completion; PRDATA keeps its value
               PREADY  <= 1'b0;
               PSLVERR <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb2axi.sv
// Bench for apb2axi: APB master tasks, a delay-configurable AXI memory slave
// and a word-level reference memory predicting read data, errors and latency.
module tb_apb2axi;

   localparam int unsigned AW = 32;
   localparam int unsigned IW = 16;
   localparam int unsigned UW = 10;

   logic          ACLK, ARESETn;
   logic          PSEL, PENABLE, PWRITE;
   logic [31:0]   PADDR, PWDATA, PRDATA;
   logic          PREADY, PSLVERR;
   logic [IW-1:0] AWID_o, ARID_o, BID_i, RID_i;
   logic [AW-1:0] AWADDR_o, ARADDR_o;
   logic [7:0]    AWLEN_o, ARLEN_o, WSTRB_o;
   logic [2:0]    AWSIZE_o, ARSIZE_o, AWPROT_o, ARPROT_o;
   logic [1:0]    AWBURST_o, ARBURST_o, BRESP_i, RRESP_i;
   logic          AWLOCK_o, ARLOCK_o;
   logic [3:0]    AWCACHE_o, ARCACHE_o, AWREGION_o, ARREGION_o, AWQOS_o, ARQOS_o;
   logic [UW-1:0] AWUSER_o, ARUSER_o, WUSER_o, BUSER_i, RUSER_i;
   logic          AWVALID_o, AWREADY_i, WVALID_o, WREADY_i, WLAST_o;
   logic          BVALID_i, BREADY_o, ARVALID_o, ARREADY_i;
   logic [63:0]   WDATA_o, RDATA_i;
   logic          RLAST_i, RVALID_i, RREADY_o;

   apb2axi dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .AWID_o(AWID_o), .AWADDR_o(AWADDR_o), .AWLEN_o(AWLEN_o), .AWSIZE_o(AWSIZE_o),
      .AWBURST_o(AWBURST_o), .AWLOCK_o(AWLOCK_o), .AWCACHE_o(AWCACHE_o), .AWPROT_o(AWPROT_o),
      .AWREGION_o(AWREGION_o), .AWQOS_o(AWQOS_o), .AWUSER_o(AWUSER_o),
      .AWVALID_o(AWVALID_o), .AWREADY_i(AWREADY_i),
      .WDATA_o(WDATA_o), .WSTRB_o(WSTRB_o), .WLAST_o(WLAST_o), .WUSER_o(WUSER_o),
      .WVALID_o(WVALID_o), .WREADY_i(WREADY_i),
      .BID_i(BID_i), .BRESP_i(BRESP_i), .BUSER_i(BUSER_i), .BVALID_i(BVALID_i), .BREADY_o(BREADY_o),
      .ARID_o(ARID_o), .ARADDR_o(ARADDR_o), .ARLEN_o(ARLEN_o), .ARSIZE_o(ARSIZE_o),
      .ARBURST_o(ARBURST_o), .ARLOCK_o(ARLOCK_o), .ARCACHE_o(ARCACHE_o), .ARPROT_o(ARPROT_o),
      .ARREGION_o(ARREGION_o), .ARQOS_o(ARQOS_o), .ARUSER_o(ARUSER_o),
      .ARVALID_o(ARVALID_o), .ARREADY_i(ARREADY_i),
      .RID_i(RID_i), .RDATA_i(RDATA_i), .RRESP_i(RRESP_i), .RLAST_i(RLAST_i), .RUSER_i(RUSER_i),
      .RVALID_i(RVALID_i), .RREADY_o(RREADY_o)
   );

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed=still running expected=finished");
      $fatal(1, "watchdog expired");
   end

   int checks = 0;
   int errors = 0;

   // Slave configuration written by the stimulus
   int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
   logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   logic        r_force = 1'b0;
   logic [63:0] r_force_data = 64'h0;

   // Slave observation state
   int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
   int          aw_cycles, w_cycles;
   logic        aw_hs, w_hs, ar_hs;
   logic        aw_stuck, w_stuck, bready_early, const_bad;
   logic [31:0] aw_addr_seen, ar_addr_seen;
   logic [63:0] w_data_seen;
   logic [7:0]  w_strb_seen;
   logic [63:0] smem [logic [28:0]];
   logic [31:0] ref_mem [logic [29:0]];

   function automatic logic [63:0] fill(input logic [28:0] k);
      return {(32'(k) * 32'h9E37_79B1) ^ 32'h0BAD_F00D, ~(32'(k) * 32'h85EB_CA6B)};
   endfunction

   function automatic logic [63:0] slave_rd(input logic [28:0] k);
      if (smem.exists(k)) return smem[k];
      return fill(k);
   endfunction

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                         input logic [7:0] s);
      logic [63:0] r;
      r = old;
      for (int i = 0; i < 8; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
      return r;
   endfunction

   // Reference: a flat 32-bit word memory, unwritten words come from the fill pattern
   function automatic logic [31:0] ref_read(input logic [31:0] a);
      logic [63:0] f;
      if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
      f = fill(a[31:3]);
      return a[2] ? f[63:32] : f[31:0];
   endfunction

   // Slave: observe handshakes on the active edge
   always @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
         aw_hs <= 1'b0; w_hs <= 1'b0; ar_hs <= 1'b0;
         aw_stuck <= 1'b0; w_stuck <= 1'b0; bready_early <= 1'b0; const_bad <= 1'b0;
      end else begin
         if (AWVALID_o && aw_hs) aw_stuck <= 1'b1;
         if (WVALID_o && w_hs)   w_stuck  <= 1'b1;
         if (AWVALID_o && AWREADY_i) begin
            aw_hs <= 1'b1; aw_addr_seen <= AWADDR_o; aw_cycles <= aw_cnt + 1;
            if (AWLEN_o != 8'd0 || AWSIZE_o != 3'b010 || AWBURST_o != 2'b01 || AWLOCK_o ||
                AWCACHE_o != 4'd0 || AWPROT_o != 3'd0 || AWREGION_o != 4'd0 ||
                AWQOS_o != 4'd0 || AWUSER_o != '0 || AWID_o != '0) const_bad <= 1'b1;
         end else if (AWVALID_o) aw_cnt <= aw_cnt + 1;
         if (WVALID_o && WREADY_i) begin
            w_hs <= 1'b1; w_data_seen <= WDATA_o; w_strb_seen <= WSTRB_o; w_cycles <= w_cnt + 1;
            if (!WLAST_o || WUSER_o != '0) const_bad <= 1'b1;
         end else if (WVALID_o) w_cnt <= w_cnt + 1;
         if (BREADY_o && !(aw_hs && w_hs)) bready_early <= 1'b1;
         if (aw_hs && w_hs) begin
            if (BVALID_i && BREADY_o) begin
               smem[aw_addr_seen[31:3]] = merge(slave_rd(aw_addr_seen[31:3]), w_data_seen, w_strb_seen);
               aw_hs <= 1'b0; w_hs <= 1'b0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
            end else b_cnt <= b_cnt + 1;
         end
         if (ARVALID_o && ARREADY_i) begin
            ar_hs <= 1'b1; ar_addr_seen <= ARADDR_o;
            if (ARLEN_o != 8'd0 || ARSIZE_o != 3'b010 || ARBURST_o != 2'b01 || ARLOCK_o ||
                ARCACHE_o != 4'd0 || ARPROT_o != 3'd0 || ARREGION_o != 4'd0 ||
                ARQOS_o != 4'd0 || ARUSER_o != '0 || ARID_o != '0) const_bad <= 1'b1;
         end else if (ARVALID_o) ar_cnt <= ar_cnt + 1;
         if (ar_hs) begin
            if (RVALID_i && RREADY_o) begin
               ar_hs <= 1'b0; ar_cnt <= 0; r_cnt <= 0;
            end else r_cnt <= r_cnt + 1;
         end
      end
   end

   // Slave: drive ready/valid on the opposite edge
   always @(negedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         AWREADY_i <= 1'b0; WREADY_i <= 1'b0; ARREADY_i <= 1'b0;
         BVALID_i <= 1'b0; BRESP_i <= 2'b00; RVALID_i <= 1'b0; RRESP_i <= 2'b00; RDATA_i <= 64'h0;
      end else begin
         AWREADY_i <= AWVALID_o && !aw_hs && (aw_cnt >= aw_delay);
         WREADY_i  <= WVALID_o && !w_hs && (w_cnt >= w_delay);
         ARREADY_i <= ARVALID_o && !ar_hs && (ar_cnt >= ar_delay);
         BVALID_i  <= aw_hs && w_hs && (b_cnt >= b_delay);
         BRESP_i   <= bresp_cfg;
         RVALID_i  <= ar_hs && (r_cnt >= r_delay);
         RRESP_i   <= rresp_cfg;
         RDATA_i   <= r_force ? r_force_data : slave_rd(ar_addr_seen[31:3]);
      end
   end

   assign BID_i   = 16'h5A5A;
   assign BUSER_i = '0;
   assign RID_i   = 16'hA5A5;
   assign RUSER_i = '0;
   assign RLAST_i = 1'b1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One APB transfer; cycles counts access-phase cycles up to and including PREADY
   task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           output logic [31:0] rdata, output logic err, output int cycles,
                           output logic timeout, output logic rdy_after, output logic err_after);
      @(negedge ACLK);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
      @(negedge ACLK);
      PENABLE = 1'b1;
      cycles = 1;
      timeout = 1'b1;
      while (cycles < 200) begin
         if (PREADY) begin
            timeout = 1'b0;
            break;
         end
         @(negedge ACLK);
         cycles++;
      end
      rdata = PRDATA;
      err = PSLVERR;
      PSEL = 1'b0; PENABLE = 1'b0;
      @(negedge ACLK);
      rdy_after = PREADY;
      err_after = PSLVERR;
   endtask

   logic [31:0] rd, a, d;
   logic        err, to, ra, ea, w;
   int          cyc, exp_cyc;

   initial begin
      ARESETn = 1'b0;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
      repeat (3) @(negedge ACLK);
      check("rst_ctrl", {PREADY, PSLVERR, AWVALID_o, WVALID_o, BREADY_o, ARVALID_o, RREADY_o}, 0);
      check("rst_prdata", PRDATA, 0);
      check("rst_addr", AWADDR_o, 0);
      ARESETn = 1'b1;

      // Zero-wait write to the upper word
      apb_xfer(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, rd, err, cyc, to, ra, ea);
      ref_mem[30'(32'h1000_0004 >> 2)] = 32'hDEAD_BEEF;
      check("wr0_timeout", to, 0);
      check("wr0_cycles", cyc, 3);
      check("wr0_awaddr", aw_addr_seen, 32'h1000_0004);
      check("wr0_wdata", w_data_seen, 64'hDEAD_BEEF_DEAD_BEEF);
      check("wr0_wstrb", w_strb_seen, 8'hF0);
      check("wr0_slverr", err, 0);
      check("wr0_pready_once", ra, 0);

      // Reads with fixed R data, lower then upper lane
      r_force = 1'b1; r_force_data = 64'h1111_2222_3333_4444;
      apb_xfer(1'b0, 32'h2000_0000, 32'h0, rd, err, cyc, to, ra, ea);
      check("rd0_araddr", ar_addr_seen, 32'h2000_0000);
      check("rd0_prdata", rd, 32'h3333_4444);
      check("rd0_cycles", cyc, 3);
      apb_xfer(1'b0, 32'h2000_0004, 32'h0, rd, err, cyc, to, ra, ea);
      check("rd1_araddr", ar_addr_seen, 32'h2000_0004);
      check("rd1_prdata", rd, 32'h1111_2222);
      check("rd1_prdata_hold", PRDATA, 32'h1111_2222);
      r_force = 1'b0;

      // AWREADY late, WREADY immediate
      aw_delay = 3;
      apb_xfer(1'b1, 32'h1000_0008, 32'hCAFE_F00D, rd, err, cyc, to, ra, ea);
      ref_mem[30'(32'h1000_0008 >> 2)] = 32'hCAFE_F00D;
      aw_delay = 0;
      check("awdly_cycles", cyc, 6);
      check("awdly_aw_cycles", aw_cycles, 4);
      check("awdly_w_cycles", w_cycles, 1);
      check("awdly_wstrb", w_strb_seen, 8'h0F);
      check("awdly_bready_early", bready_early, 0);

      // DECERR read, then a clean read clears PSLVERR
      rresp_cfg = 2'b11;
      apb_xfer(1'b0, 32'h1000_0004, 32'h0, rd, err, cyc, to, ra, ea);
      check("decerr_slverr", err, 1);
      check("decerr_prdata", rd, ref_read(32'h1000_0004));
      check("decerr_slverr_clear", ea, 0);
      rresp_cfg = 2'b00;
      apb_xfer(1'b0, 32'h1000_0008, 32'h0, rd, err, cyc, to, ra, ea);
      check("okay_slverr", err, 0);
      check("okay_prdata", rd, ref_read(32'h1000_0008));

      // Slow write response
      b_delay = 10;
      apb_xfer(1'b1, 32'h1000_0010, 32'h0123_4567, rd, err, cyc, to, ra, ea);
      ref_mem[30'(32'h1000_0010 >> 2)] = 32'h0123_4567;
      b_delay = 0;
      check("bdly_cycles", cyc, 13);
      check("bdly_pready_once", ra, 0);

      // Random traffic against the reference memory
      for (int n = 0; n < 40; n++) begin
         w = 1'($urandom_range(0, 1));
         a = 32'h4000_0000 | (32'($urandom_range(0, 15)) << 2);
         d = $urandom;
         aw_delay = int'($urandom_range(0, 3)); w_delay = int'($urandom_range(0, 3));
         b_delay  = int'($urandom_range(0, 3)); ar_delay = int'($urandom_range(0, 3));
         r_delay  = int'($urandom_range(0, 3));
         bresp_cfg = 2'($urandom_range(0, 3)); rresp_cfg = bresp_cfg;
         apb_xfer(w, a, d, rd, err, cyc, to, ra, ea);
         exp_cyc = w ? 3 + ((aw_delay > w_delay) ? aw_delay : w_delay) + b_delay
                     : 3 + ar_delay + r_delay;
         check("rnd_timeout", to, 0);
         check("rnd_cycles", cyc, exp_cyc);
         check("rnd_slverr", err, (bresp_cfg >= 2'b10) ? 1 : 0);
         check("rnd_after", {ra, ea}, 0);
         if (w) begin
            check("rnd_awaddr", aw_addr_seen, a);
            check("rnd_wdata", w_data_seen, {d, d});
            check("rnd_wstrb", w_strb_seen, (a % 8 == 4) ? 8'hF0 : 8'h0F);
            ref_mem[a[31:2]] = d;
         end else begin
            check("rnd_araddr", ar_addr_seen, a);
            check("rnd_prdata", rd, ref_read(a));
         end
      end
      aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
      bresp_cfg = 2'b00; rresp_cfg = 2'b00;
      check("proto_flags", {const_bad, aw_stuck, w_stuck, bready_early}, 0);

      // Reset while ARVALID is pending
      ar_delay = 40;
      @(negedge ACLK);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h4000_0010;
      @(negedge ACLK);
      PENABLE = 1'b1;
      check("arst_arvalid_before", ARVALID_o, 1);
      #2 ARESETn = 1'b0;
      #1;
      check("arst_arvalid", ARVALID_o, 0);
      check("arst_pready", {PREADY, PSLVERR, RREADY_o}, 0);
      PSEL = 1'b0; PENABLE = 1'b0; ar_delay = 0;
      @(negedge ACLK);
      @(negedge ACLK);
      ARESETn = 1'b1;
      apb_xfer(1'b0, 32'h4000_0010, 32'h0, rd, err, cyc, to, ra, ea);
      check("arst_rd_cycles", cyc, 3);
      check("arst_rd_prdata", rd, ref_read(32'h4000_0010));
      check("arst_rd_slverr", err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
